// File: rtl/scu_sequencer.sv
// Instruction sequencer: fetches program words from a synchronous-read ROM, feeds the
// processor's Din/Run handshake, and stops on halt, program end or a Done watchdog timeout.
module scu_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PROG_LEN = 256,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [2:0]  OP_MVI   = 3'b001,
    parameter logic [2:0]  OP_HALT  = 3'b111
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       Din,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]  LEN     = (ADDR_W + 1)'(PROG_LEN);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_LOADIMM = 3'd3,
        S_ISSUE   = 3'd4,
        S_WAIT    = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [15:0]       r_din;
    logic              r_run;
    logic [15:0]       r_count;
    logic              r_error;
    logic [15:0]       r_instr;
    logic [15:0]       r_imm;
    logic              r_is_mvi;
    logic [WD_W-1:0]   r_wd;

    logic [ADDR_W:0]   w_pc_p1;
    logic [ADDR_W:0]   w_pc_next;
    logic [2:0]        w_opcode;

    // Program-length checks run one bit wider than the address so pc itself never wraps.
    assign w_pc_p1   = {1'b0, r_pc} + (ADDR_W + 1)'(1);
    assign w_pc_next = r_is_mvi ? ({1'b0, r_pc} + (ADDR_W + 1)'(2)) : w_pc_p1;
    assign w_opcode  = mem_rdata[8:6];

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_din      <= '0;
            r_run      <= 1'b0;
            r_count    <= '0;
            r_error    <= 1'b0;
            r_instr    <= '0;
            r_imm      <= '0;
            r_is_mvi   <= 1'b0;
            r_wd       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    r_run    <= 1'b0;
                    r_mem_rd <= 1'b0;
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= '0;
                        r_count    <= '0;
                        r_error    <= 1'b0;
                        r_mem_addr <= '0;
                        r_mem_rd   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // Read pc+1 speculatively so an mvi immediate is ready one cycle after LOAD.
                    r_state    <= S_LOAD;
                    r_mem_addr <= w_pc_p1[ADDR_W-1:0];
                    r_mem_rd   <= (w_pc_p1 < LEN);
                end
                S_LOAD: begin
                    r_mem_rd <= 1'b0;
                    r_instr  <= mem_rdata;
                    r_is_mvi <= (w_opcode == OP_MVI);
                    if (w_opcode == OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (w_opcode == OP_MVI) begin
                        if (w_pc_p1 >= LEN) begin
                            r_error <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_LOADIMM;
                        end
                    end else begin
                        r_din   <= mem_rdata;
                        r_run   <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_LOADIMM: begin
                    r_imm   <= mem_rdata;
                    r_din   <= r_instr;
                    r_run   <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_run   <= 1'b0;
                    r_wd    <= '0;
                    r_din   <= r_is_mvi ? r_imm : r_instr;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (Done) begin
                        r_count <= r_count + 16'd1;
                        // At program end pc stays on the last retired instruction.
                        if (w_pc_next >= LEN) begin
                            r_state <= S_HALT;
                        end else begin
                            r_pc       <= w_pc_next[ADDR_W-1:0];
                            r_mem_addr <= w_pc_next[ADDR_W-1:0];
                            r_mem_rd   <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end else if (r_wd == WD_LAST) begin
                        r_error <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;
    assign Din         = r_din;
    assign Run         = r_run;
    assign pc          = r_pc;
    assign instr_count = r_count;
    assign error       = r_error;
    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_scu_sequencer.sv
// Directed bench for scu_sequencer: behavioural ROM and processor model around a
// PROG_LEN=3 instance, with hand-computed expectations checked at falling edges.
module tb_scu_sequencer;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] Din;
    logic        Run;
    logic        Done;
    logic [7:0]  pc;
    logic [15:0] instr_count;
    logic        busy;
    logic        halted;
    logic        error;

    logic [15:0] rom [0:255];
    logic        proc_en;
    logic        force_done;
    logic        model_done = 1'b0;
    int          dly = 0;
    int          run_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [15:0] W_MV   = 16'h0008;
    localparam logic [15:0] W_ADD  = 16'h0080;
    localparam logic [15:0] W_MVI  = 16'h0040;
    localparam logic [15:0] W_HALT = 16'h01C0;

    scu_sequencer #(.ADDR_W(8), .PROG_LEN(3), .TIMEOUT(16)) dut (
        .clk(clk), .Reset(Reset), .start(start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .Din(Din), .Run(Run), .Done(Done),
        .pc(pc), .instr_count(instr_count),
        .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

    // Processor stand-in: Done pulse a fixed two cycles after it sees Run.
    always @(posedge clk) begin
        if (Run && proc_en) dly <= 2;
        else if (dly != 0) dly <= dly - 1;
        model_done <= proc_en && (dly == 1);
        if (Run) run_cnt <= run_cnt + 1;
    end
    assign Done = model_done | force_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int i = 0; i < 256; i++) rom[i] = W_HALT;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 40 && !Run; i++) @(negedge clk);
        check(tag, Run, 1'b1);
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
        check(tag, halted, 1'b1);
    endtask

    initial begin
        int run0;
        int wcnt;
        Reset = 1'b1; start = 1'b0; proc_en = 1'b1; force_done = 1'b0;
        load_prog(W_MV, W_HALT, W_HALT);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_memrd", mem_rd, 1'b0);
        check("rst_din", Din, 16'h0000);
        Reset = 1'b0;

        // Done outside S_WAIT has no effect.
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        check("idle_done_count", instr_count, 16'd0);
        check("idle_done_busy", busy, 1'b0);

        // mv then halt: Run in the 4th cycle counting the start cycle.
        run0 = run_cnt;
        pulse_start();
        check("t1_fetch_busy", busy, 1'b1);
        check("t1_fetch_rd", mem_rd, 1'b1);
        check("t1_fetch_addr", mem_addr, 8'd0);
        check("t1_fetch_run", Run, 1'b0);
        @(negedge clk);
        check("t1_load_run", Run, 1'b0);
        @(negedge clk);
        check("t1_issue_run", Run, 1'b1);
        check("t1_issue_din", Din, W_MV);
        wait_halt("t1_halt_seen");
        check("t1_count", instr_count, 16'd1);
        check("t1_pc", pc, 8'd1);
        check("t1_error", error, 1'b0);
        check("t1_busy", busy, 1'b0);
        check("t1_runs", run_cnt - run0, 1);

        // mvi with immediate, then halt.
        load_prog(W_MVI, 16'h1234, W_HALT);
        run0 = run_cnt;
        pulse_start();
        wait_run("t2_run_seen");
        check("t2_issue_din", Din, W_MVI);
        check("t2_issue_pc", pc, 8'd0);
        @(negedge clk);
        check("t2_wait_din", Din, 16'h1234);
        check("t2_wait_run", Run, 1'b0);
        for (int i = 0; i < 40 && !Done; i++) @(negedge clk);
        check("t2_done_din", Din, 16'h1234);
        wait_halt("t2_halt_seen");
        check("t2_pc", pc, 8'd2);
        check("t2_count", instr_count, 16'd1);
        check("t2_halt_din", Din, 16'h1234);
        check("t2_runs", run_cnt - run0, 1);

        // Watchdog: no Done ever.
        proc_en = 1'b0;
        load_prog(W_ADD, W_HALT, W_HALT);
        pulse_start();
        wait_run("t3_run_seen");
        wcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            wcnt++;
        end
        check("t3_wait_cycles", wcnt, 16);
        check("t3_error", error, 1'b1);
        check("t3_halted", halted, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_count", instr_count, 16'd0);

        // Restart from an errored halt; mvi in the last word runs off the end.
        proc_en = 1'b1;
        load_prog(W_ADD, W_ADD, W_MVI);
        run0 = run_cnt;
        pulse_start();
        check("t4_err_clear", error, 1'b0);
        check("t4_restart_pc", pc, 8'd0);
        wait_halt("t4_halt_seen");
        check("t4_count", instr_count, 16'd2);
        check("t4_pc", pc, 8'd2);
        check("t4_error", error, 1'b1);
        check("t4_runs", run_cnt - run0, 2);

        // Running into PROG_LEN halts cleanly.
        load_prog(W_ADD, W_ADD, W_ADD);
        pulse_start();
        wait_halt("t5_halt_seen");
        check("t5_count", instr_count, 16'd3);
        check("t5_pc", pc, 8'd2);
        check("t5_error", error, 1'b0);

        // start while busy is ignored.
        load_prog(W_ADD, W_HALT, W_HALT);
        pulse_start();
        wait_run("t6_run_seen");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_busy_start_busy", busy, 1'b1);
        check("t6_busy_start_pc", pc, 8'd0);
        wait_halt("t6_halt_seen");
        check("t6_count", instr_count, 16'd1);
        check("t6_pc", pc, 8'd1);

        // Reset in S_WAIT of an mvi, then rerun.
        proc_en = 1'b0;
        load_prog(W_MVI, 16'hBEEF, W_HALT);
        pulse_start();
        wait_run("t7_run_seen");
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check("t7_rst_din", Din, 16'h0000);
        check("t7_rst_run", Run, 1'b0);
        check("t7_rst_memrd", mem_rd, 1'b0);
        check("t7_rst_addr", mem_addr, 8'd0);
        check("t7_rst_pc", pc, 8'd0);
        check("t7_rst_count", instr_count, 16'd0);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_halted", halted, 1'b0);
        check("t7_rst_error", error, 1'b0);
        proc_en = 1'b1;
        pulse_start();
        wait_halt("t7_halt_seen");
        check("t7_pc", pc, 8'd2);
        check("t7_count", instr_count, 16'd1);
        check("t7_din", Din, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
